// File: rtl/pipelined_adder_pkg.sv
// Shared types and elaboration helpers for the carry-pipelined adder.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Bits resolved per pipeline stage.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  // Legal geometry: at least one stage, no more stages than bits, even split.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result bus of the pipelined adder.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/pipelined_adder_slice.sv
// Combinational W-bit ripple-carry slice built from single-bit full adders.
module adder_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry rippling upward.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];
  assign cmsb = c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract, carry-pipelined over STAGES register stages with valid/ready.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_adder_if.slave  bus
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  op_e  op;
  logic advance;
  logic accept;

  // Stage registers: w_q holds finished low sum bits plus still-unprocessed bits of a,
  // b_q carries the (possibly inverted) b operand forward with its op.
  logic             vld_q [STAGES];
  logic             cy_q  [STAGES];
  logic [WIDTH-1:0] w_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic             cmsb_q;

  logic             vld_in [STAGES];
  logic             cin_in [STAGES];
  logic [WIDTH-1:0] w_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] w_nxt  [STAGES];
  logic [CHUNK-1:0] s_c    [STAGES];
  logic             co_c   [STAGES];
  logic             cm_c   [STAGES];

  assign op           = op_e'(bus.sub);
  assign advance      = !vld_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = advance && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  // Stage inputs: stage 0 from the bus, later stages from the previous register.
  always_comb begin
    vld_in[0] = accept;
    cin_in[0] = (op == OP_SUB) ? 1'b1 : bus.c_in;
    w_in[0]   = bus.a;
    b_in[0]   = (op == OP_SUB) ? ~bus.b : bus.b;
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      cin_in[k] = cy_q[k-1];
      w_in[k]   = w_q[k-1];
      b_in[k]   = b_q[k-1];
    end
  end

  // One ripple slice per stage on that stage's chunk.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(.W(CHUNK)) u_slice (
      .a    (w_in[k][k*CHUNK +: CHUNK]),
      .b    (b_in[k][k*CHUNK +: CHUNK]),
      .cin  (cin_in[k]),
      .sum  (s_c[k]),
      .cout (co_c[k]),
      .cmsb (cm_c[k])
    );
  end

  // Splice each stage's chunk result into its word; other bits pass unchanged.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_nxt[k] = w_in[k];
      w_nxt[k][k*CHUNK +: CHUNK] = s_c[k];
    end
  end

  // Pipeline registers: clear on reset, shift together on advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        w_q[k]   <= '0;
        b_q[k]   <= '0;
      end
      cmsb_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_in[k];
        cy_q[k]  <= co_c[k];
        w_q[k]   <= w_nxt[k];
        b_q[k]   <= b_in[k];
      end
      cmsb_q <= cm_c[STAGES-1];
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = w_q[STAGES-1];
  assign bus.c_out     = cy_q[STAGES-1];
  assign bus.overflow  = cy_q[STAGES-1] ^ cmsb_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomized checks of pipelined_adder in 4-, 1- and 16-stage builds.
module tb_pipelined_adder;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) mif ();
  pipelined_adder_if #(.WIDTH(W)) s1if ();
  pipelined_adder_if #(.WIDTH(W)) s16if ();

  pipelined_adder #(.WIDTH(W), .STAGES(4))  dut     (.clk(clk), .rst(rst), .bus(mif));
  pipelined_adder #(.WIDTH(W), .STAGES(1))  dut_s1  (.clk(clk), .rst(rst), .bus(s1if));
  pipelined_adder #(.WIDTH(W), .STAGES(16)) dut_s16 (.clk(clk), .rst(rst), .bus(s16if));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {sum, c_out, overflow}
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] t;
    logic        ov;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + 17'(sub ? 1'b1 : cin);
    ov = (a[15] == bb[15]) && (t[15] != a[15]);
    return {t[15:0], t[16], ov};
  endfunction

  // Single op on the 4-stage unit with out_ready high; checks result and latency.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    bit acc;
    bit got;
    mif.a = a; mif.b = b; mif.c_in = cin; mif.sub = sub;
    mif.in_valid = 1'b1; mif.out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      acc = mif.in_ready;
      tick();
    end
    mif.in_valid = 1'b0;
    check({tag, " accept"}, 32'(acc), 32'd1);
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (mif.out_valid) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " sum"}, 32'(mif.sum), 32'(es));
    check({tag, " c_out"}, 32'(mif.c_out), 32'(ec));
    check({tag, " overflow"}, 32'(mif.overflow), 32'(eo));
    tick();
  endtask

  logic [15:0] exp_s [8] = '{16'h0101, 16'h1212, 16'h2323, 16'h3434,
                             16'h4545, 16'h5656, 16'h6767, 16'h7878};

  logic [17:0] q1 [$];
  logic [17:0] q16 [$];

  initial begin
    int          sent, got;
    bit          hold, stale;
    logic [15:0] prev_sum;
    bit          pend [2];
    logic [15:0] ra [2];
    logic [15:0] rb [2];
    logic        rc [2];
    logic        rs [2];
    int          acc_n [2];
    int          got_n [2];
    logic [17:0] e;

    rst = 1'b1;
    mif.in_valid = 1'b0; mif.out_ready = 1'b1; mif.a = '0; mif.b = '0; mif.c_in = 1'b0; mif.sub = 1'b0;
    s1if.in_valid = 1'b0; s1if.out_ready = 1'b1; s1if.a = '0; s1if.b = '0; s1if.c_in = 1'b0; s1if.sub = 1'b0;
    s16if.in_valid = 1'b0; s16if.out_ready = 1'b1; s16if.a = '0; s16if.b = '0; s16if.c_in = 1'b0; s16if.sub = 1'b0;
    repeat (3) tick();

    // Reset state
    #1;
    check("rst in_ready", 32'(mif.in_ready), 32'd0);
    check("rst out_valid", 32'(mif.out_valid), 32'd0);
    check("rst sum", 32'(mif.sum), 32'd0);
    check("rst c_out", 32'(mif.c_out), 32'd0);
    check("rst overflow", 32'(mif.overflow), 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 32'(mif.in_ready), 32'd1);
    tick();

    // Directed single ops
    do_op("t1 carry-chunk", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("t2 wrap", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("t3 add ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("t3 sub ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("t3 sub borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub cin ignored", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0);
    do_op("add cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    do_op("neg+neg ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Back-to-back stream with a 3-cycle output stall
    sent = 0; got = 0; hold = 1'b0; prev_sum = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (sent < 8) begin
        mif.in_valid = 1'b1;
        mif.a = 16'(16'h1111 * sent);
        mif.b = 16'h0101; mif.c_in = 1'b0; mif.sub = 1'b0;
      end else mif.in_valid = 1'b0;
      mif.out_ready = !(c >= 6 && c <= 8);
      #1;
      if (hold) begin
        check("stall hold valid", 32'(mif.out_valid), 32'd1);
        check("stall hold sum", 32'(mif.sum), 32'(prev_sum));
      end
      if (mif.out_valid && !mif.out_ready) check("stall in_ready", 32'(mif.in_ready), 32'd0);
      if (mif.out_valid && mif.out_ready) begin
        check($sformatf("stream[%0d]", got), 32'({mif.c_out, mif.overflow, mif.sum}),
              32'({2'b00, exp_s[got]}));
        got++;
      end
      hold = mif.out_valid && !mif.out_ready;
      prev_sum = mif.sum;
      if (mif.in_valid && mif.in_ready) sent++;
      tick();
    end
    mif.in_valid = 1'b0; mif.out_ready = 1'b1;
    check("stream results", 32'(got), 32'd8);
    check("stream accepts", 32'(sent), 32'd8);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      mif.in_valid = 1'b1;
      mif.a = 16'h0F0F; mif.b = 16'(i + 1); mif.c_in = 1'b0; mif.sub = 1'b0;
      #1;
      check("inflight accept", 32'(mif.in_ready), 32'd1);
      tick();
    end
    mif.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("pulse in_ready", 32'(mif.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    check("pulse out_valid", 32'(mif.out_valid), 32'd0);
    check("pulse sum", 32'(mif.sum), 32'd0);
    check("pulse c_out", 32'(mif.c_out), 32'd0);
    check("pulse overflow", 32'(mif.overflow), 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mif.out_valid) stale = 1'b1;
      tick();
    end
    check("no stale result", 32'(stale), 32'd0);
    do_op("after reset", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

    // Random ops with random backpressure on the 1- and 16-stage builds
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; acc_n[k] = 0; got_n[k] = 0;
      ra[k] = '0; rb[k] = '0; rc[k] = 1'b0; rs[k] = 1'b0;
    end
    for (int c = 0; c < 6000 && (got_n[0] < 1000 || got_n[1] < 1000); c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && acc_n[k] < 1000 && $urandom_range(0, 3) != 0) begin
          pend[k] = 1'b1;
          ra[k] = 16'($urandom);
          rb[k] = 16'($urandom);
          rc[k] = 1'($urandom);
          rs[k] = 1'($urandom);
        end
      end
      s1if.in_valid = pend[0]; s1if.a = ra[0]; s1if.b = rb[0]; s1if.c_in = rc[0]; s1if.sub = rs[0];
      s1if.out_ready = ($urandom_range(0, 3) != 0);
      s16if.in_valid = pend[1]; s16if.a = ra[1]; s16if.b = rb[1]; s16if.c_in = rc[1]; s16if.sub = rs[1];
      s16if.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (s1if.out_valid && s1if.out_ready) begin
        check("s1 expected pending", 32'(q1.size() > 0), 32'd1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check($sformatf("s1 result[%0d]", got_n[0]),
                32'({s1if.sum, s1if.c_out, s1if.overflow}), 32'(e));
        end
        got_n[0]++;
      end
      if (s1if.in_valid && s1if.in_ready) begin
        q1.push_back(ref_op(ra[0], rb[0], rc[0], rs[0]));
        pend[0] = 1'b0;
        acc_n[0]++;
      end
      if (s16if.out_valid && s16if.out_ready) begin
        check("s16 expected pending", 32'(q16.size() > 0), 32'd1);
        if (q16.size() > 0) begin
          e = q16.pop_front();
          check($sformatf("s16 result[%0d]", got_n[1]),
                32'({s16if.sum, s16if.c_out, s16if.overflow}), 32'(e));
        end
        got_n[1]++;
      end
      if (s16if.in_valid && s16if.in_ready) begin
        q16.push_back(ref_op(ra[1], rb[1], rc[1], rs[1]));
        pend[1] = 1'b0;
        acc_n[1]++;
      end
      tick();
    end
    s1if.in_valid = 1'b0;
    s16if.in_valid = 1'b0;
    check("s1 result count", 32'(got_n[0]), 32'd1000);
    check("s16 result count", 32'(got_n[1]), 32'd1000);
    check("s1 queue drained", 32'(q1.size()), 32'd0);
    check("s16 queue drained", 32'(q16.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
